timer_io: RTL and testbench
===========================

Name: timer_io

Overview:
- Memory-mapped down-counting timer peripheral that sits directly downstream of the system address decoder.
- Selected by that decoder's timer chip-select (cs_io[3], window 0xc000-0xcfff); only the low word-address bits reach this block.
- Provides prescaled countdown, one-shot or auto-reload mode, a sticky underflow flag and a level interrupt.
- Read data is gated to zero when not selected, so the CPU-side read mux can OR all peripheral outputs.

Parameters:
- DATA_WIDTH, 32, width of the bus data and of the counter/reload registers.
- PRESCALE_WIDTH, 8, width of the CTRL prescale field.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  chip select from the address decoder (timer window).
- wen  input  1  write enable; a write is cs & wen, a read is cs & ~wen.
- addr  input  4  register index (bus word address bits [3:0]).
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  read data, combinational.
- irq  output  1  interrupt request, level.

Behaviour:
- Register map (addr):
  - 0 CTRL: bit0 RUN, bit1 AUTO (auto-reload), bit2 IE; bits[8+PRESCALE_WIDTH-1:8] PRE; other bits read 0.
  - 1 RELOAD.
  - 2 COUNT (read gives the live value; write loads it).
  - 3 STATUS: bit0 OVF, write-1-to-clear.
  - addr 4-15: reads return 0, writes are ignored.
- Reset: CTRL=0, RELOAD=0, COUNT=0, OVF=0, prescaler=0, irq=0. dout=0 whenever cs=0 or wen=1.
- Read: dout = selected register when cs & ~wen, in the same cycle (zero wait states). Reads have no side effects.
- Write: takes effect at the next rising edge. A CTRL write also clears the prescaler to 0.
- Prescaler:
  - Runs only while RUN=1. When RUN=0 it holds at 0.
  - Counts 0..PRE. A tick is asserted in the cycle where prescaler==PRE, and the prescaler returns to 0 on that cycle.
  - With PRE=0 a tick occurs every cycle. In general the period is PRE+1 cycles.
- On a tick:
  - If COUNT!=0: COUNT <= COUNT-1.
  - If COUNT==0 (underflow): OVF <= 1.
    - AUTO=1: COUNT <= RELOAD.
    - AUTO=0: RUN <= 0 and COUNT stays 0 (one-shot stop).
- Underflow occurs on the tick after COUNT reaches 0. A load of N therefore gives N+1 ticks to underflow.
- irq = OVF & IE, registered through OVF with no extra latency. It stays high until OVF is cleared or IE is cleared.
- Simultaneous events:
  - COUNT write and tick in the same cycle: the write wins and the decrement is lost.
  - STATUS clear and underflow in the same cycle: set wins, OVF=1.
  - CTRL write and one-shot stop in the same cycle: the written RUN wins.
- Arithmetic is unsigned with no wrap below 0 (an underflow reloads or stops instead). RELOAD=0 with AUTO=1 gives an underflow every tick.
- Reset asserted mid-count: every register returns to its reset value on that edge, and irq drops the following cycle.

Test Plan:
- Reset, then read addr 0..3 -> all 0. irq=0. Read with cs=0 -> dout=0.
- Write RELOAD=3, COUNT=3, CTRL=0x3 (RUN, AUTO, PRE=0) -> COUNT reads 3,2,1,0 on successive cycles; OVF=1 on the 5th cycle; COUNT=3 again; RUN stays 1.
- One-shot: COUNT=2, CTRL=0x0401 (RUN, PRE=4) -> decrement every 5 cycles; OVF set 15 cycles after the write; RUN reads 0; COUNT holds 0.
- IE=1 with an underflow -> irq=1. Write STATUS=1 -> irq=0 next cycle. Repeat with the STATUS clear coinciding with an underflow -> OVF remains 1.
- COUNT write of 0x100 in the same cycle as a tick -> COUNT reads 0x100, not 0xFF. Write to addr 7 -> no register changes; read of addr 7 -> 0.
- Reset pulse while running with OVF=1 and IE=1 -> all registers read 0 and irq=0 after the edge.

Source files
------------

// File: rtl/timer_io_if.sv
// rtl/timer_io_if.sv - register bus between the address decoder window and the timer
interface timer_io_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cs;
  logic                  wen;
  logic [3:0]            addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    output cs,
    output wen,
    output addr,
    output din,
    input  dout
  );

  modport slave (
    input  cs,
    input  wen,
    input  addr,
    input  din,
    output dout
  );
endinterface

// File: rtl/timer_io.sv
// rtl/timer_io.sv - prescaled down-counting timer with auto-reload, sticky underflow and level irq
module timer_io #(
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  timer_io_if.slave   bus,
  output logic        irq
);

  logic                      run;
  logic                      auto_rl;
  logic                      ie;
  logic [PRESCALE_WIDTH-1:0] pre;
  logic [PRESCALE_WIDTH-1:0] prescaler;
  logic [DATA_WIDTH-1:0]     reload;
  logic [DATA_WIDTH-1:0]     count;
  logic                      ovf;

  logic wr;
  logic tick;
  logic underflow;

  assign wr        = bus.cs & bus.wen;
  assign tick      = run && (prescaler == pre);
  assign underflow = tick && (count == '0);
  assign irq       = ovf & ie;

  // Bus writes are applied after the tick logic so that a same-cycle write overrides it;
  // the only exception is the STATUS clear, where a simultaneous underflow must win.
  always_ff @(posedge clk) begin
    if (reset) begin
      run       <= 1'b0;
      auto_rl   <= 1'b0;
      ie        <= 1'b0;
      pre       <= '0;
      prescaler <= '0;
      reload    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
    end else begin
      if (run && !tick) begin
        prescaler <= prescaler + PRESCALE_WIDTH'(1);
      end else begin
        prescaler <= '0;
      end

      if (underflow) begin
        ovf <= 1'b1;
        if (auto_rl) begin
          count <= reload;
        end else begin
          run <= 1'b0;
        end
      end else if (tick) begin
        count <= count - DATA_WIDTH'(1);
      end

      if (wr) begin
        case (bus.addr)
          4'd0: begin
            run       <= bus.din[0];
            auto_rl   <= bus.din[1];
            ie        <= bus.din[2];
            pre       <= bus.din[8 +: PRESCALE_WIDTH];
            prescaler <= '0;
          end
          4'd1: reload <= bus.din;
          4'd2: count  <= bus.din;
          4'd3: begin
            if (bus.din[0] && !underflow) begin
              ovf <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read data is forced to zero outside a read so the CPU-side mux can OR peripherals.
  always_comb begin
    bus.dout = '0;
    if (bus.cs && !bus.wen) begin
      case (bus.addr)
        4'd0: begin
          bus.dout[0]                     = run;
          bus.dout[1]                     = auto_rl;
          bus.dout[2]                     = ie;
          bus.dout[8 +: PRESCALE_WIDTH]   = pre;
        end
        4'd1:    bus.dout = reload;
        4'd2:    bus.dout = count;
        4'd3:    bus.dout[0] = ovf;
        default: bus.dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_io.sv
// tb/tb_timer_io.sv - directed and randomized checks of timer_io against a behavioural model
module tb_timer_io;

  logic clk;
  logic reset;
  logic irq;

  timer_io_if #(.DATA_WIDTH(32)) bus ();

  timer_io #(
    .DATA_WIDTH     (32),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Behavioural model state, kept as the programmer-visible registers plus the prescale phase.
  bit        m_run, m_auto, m_ie, m_ovf;
  int        m_pre;
  int        m_phase;
  bit [31:0] m_reload, m_count;

  logic [31:0] rd_data;
  logic        irq_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] model_read(input int a);
    case (a)
      0:       return {16'h0, 8'(m_pre), 5'h0, m_ie, m_auto, m_run};
      1:       return m_reload;
      2:       return m_count;
      3:       return {31'h0, m_ovf};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit cs, input bit wen, input int a, input bit [31:0] d);
    bit tick, uf;
    if (rst) begin
      m_run = 0; m_auto = 0; m_ie = 0; m_ovf = 0;
      m_pre = 0; m_phase = 0; m_reload = 0; m_count = 0;
      return;
    end
    tick = m_run && (m_phase == m_pre);
    uf   = tick && (m_count == 0);
    m_phase = (m_run && !tick) ? m_phase + 1 : 0;
    if (uf) begin
      m_ovf = 1;
      if (m_auto) m_count = m_reload;
      else        m_run = 0;
    end else if (tick) begin
      m_count = m_count - 1;
    end
    if (cs && wen) begin
      case (a)
        0: begin
          m_run = d[0]; m_auto = d[1]; m_ie = d[2];
          m_pre = int'(d[15:8]); m_phase = 0;
        end
        1: m_reload = d;
        2: m_count = d;
        3: if (d[0] && !uf) m_ovf = 0;
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive, check combinational outputs mid-cycle, then advance model on the edge.
  task automatic cycle(input bit rst, input bit cs, input bit wen, input int a, input bit [31:0] d);
    reset    = rst;
    bus.cs   = cs;
    bus.wen  = wen;
    bus.addr = 4'(a);
    bus.din  = d;
    @(negedge clk);
    check("dout", bus.dout, (cs && !wen) ? model_read(a) : 32'h0);
    check("irq", {31'h0, irq}, {31'h0, m_ovf & m_ie});
    rd_data = bus.dout;
    irq_s   = irq;
    @(posedge clk);
    model_step(rst, cs, wen, a, d);
    #1;
  endtask

  task automatic wr(input int a, input bit [31:0] d);
    cycle(0, 1, 1, a, d);
  endtask

  task automatic rd(input int a);
    cycle(0, 1, 0, a, 32'h0);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b1;
    bus.cs   = 1'b0;
    bus.wen  = 1'b0;
    bus.addr = 4'h0;
    bus.din  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_step(1, 0, 0, 0, 0);

    // Reset state
    for (int a = 0; a < 4; a++) begin
      rd(a);
      check("reset_reg", rd_data, 32'h0);
    end
    check("reset_irq", {31'h0, irq_s}, 32'h0);

    // Auto-reload, PRE=0
    wr(1, 3);
    wr(2, 3);
    wr(0, 32'h3);
    for (int k = 3; k >= 0; k--) begin
      rd(2);
      check("auto_count", rd_data, 32'(k));
    end
    rd(3);
    check("auto_ovf", rd_data, 32'h1);
    cycle(0, 0, 0, 2, 32'h0);
    check("cs0_dout", rd_data, 32'h0);
    rd(0);
    check("auto_run", rd_data, 32'h3);
    wr(0, 0);
    wr(3, 1);

    // One-shot with PRE=4: underflow 15 cycles after the CTRL write
    wr(2, 2);
    wr(0, 32'h401);
    repeat (14) idle();
    rd(3);
    check("oneshot_pre", rd_data, 32'h0);
    rd(3);
    check("oneshot_ovf", rd_data, 32'h1);
    rd(0);
    check("oneshot_ctrl", rd_data, 32'h400);
    rd(2);
    check("oneshot_count", rd_data, 32'h0);
    wr(3, 1);

    // Interrupt, clear coinciding with underflow, then a plain clear
    wr(1, 0);
    wr(2, 0);
    wr(0, 32'h7);
    idle();
    idle();
    check("irq_set", {31'h0, irq_s}, 32'h1);
    wr(3, 1);
    rd(3);
    check("clr_vs_set", rd_data, 32'h1);
    wr(0, 32'h4);
    wr(3, 1);
    idle();
    check("irq_clr", {31'h0, irq_s}, 32'h0);

    // COUNT write against a tick, and unmapped address
    wr(0, 32'h3);
    wr(2, 32'h100);
    rd(2);
    check("wr_vs_tick", rd_data, 32'h100);
    wr(0, 0);
    wr(7, 32'hFFFF_FFFF);
    rd(7);
    check("addr7_rd", rd_data, 32'h0);
    rd(1);
    check("addr7_reload", rd_data, 32'h0);
    rd(0);
    check("addr7_ctrl", rd_data, 32'h0);

    // Reset while running with OVF and IE set
    wr(0, 32'h7);
    idle();
    idle();
    check("pre_rst_irq", {31'h0, irq_s}, 32'h1);
    cycle(1, 0, 0, 0, 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(a);
      check("post_rst_reg", rd_data, 32'h0);
    end
    check("post_rst_irq", {31'h0, irq_s}, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int        r, a;
      bit        cs, wen;
      bit [31:0] d;
      r   = int'($urandom_range(0, 99));
      cs  = (r < 60);
      wen = ($urandom_range(0, 2) == 0);
      a   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
      d   = $urandom;
      if (a == 0) begin
        d[15:8] = 8'($urandom_range(0, 3));
        d[0]    = ($urandom_range(0, 3) != 0);
      end else if (a == 1 || a == 2) begin
        d = 32'($urandom_range(0, 12));
      end
      cycle(r == 99, cs, wen, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
